kernel_3x3_gauss: RTL and testbench
===================================

KERNEL_3X3_GAUSS -- requirements
Module: kernel

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; no other clocks or asynchronous paths.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous reset, active-high (1 = reset), sampled on rising clk.
REQ-004 top  input  8  unsigned pixel, top row of incoming column.
REQ-005 mid  input  8  unsigned pixel, middle row of incoming column.
REQ-006 bot  input  8  unsigned pixel, bottom row of incoming column.
REQ-007 valid_in  input  1  column (top, mid, bot) is valid this cycle; shift it into the window.
REQ-008 top_edge  input  1  window's top row lies outside the image; treat as zero.
REQ-009 bot_edge  input  1  window's bottom row lies outside the image; treat as zero.
REQ-010 left_edge  input  1  oldest column (c0) lies outside the image; treat as zero.
REQ-011 right_edge  input  1  newest column (c2) lies outside the image; treat as zero.
REQ-012 pixel_out  output  8  Gaussian-filtered centre pixel.
REQ-013 valid_out  output  1  pixel_out corresponds to a full window updated by the previous column shift.

Function
REQ-014 SHALL hold a 3x3 window of three 3-pixel columns c0 (oldest), c1, c2 (newest), each holding top/mid/bot.
REQ-015 On a rising clk with valid_in=1: c0<=c1, c1<=c2, c2<={top,mid,bot}; with valid_in=0 the window holds.
REQ-016 Weights: corners 1, edge-centres 2, centre (c1.mid) 4; total 16.
REQ-017 Edge masking SHALL zero the affected pixels before weighting: top_edge zeros top row of c0..c2, bot_edge zeros bottom row, left_edge zeros c0, right_edge zeros c2; flags combine by OR per pixel (overlapping corner zeroed once).
REQ-018 Weighted sum SHALL be computed unsigned in at least 12 bits (max 4080); no normalisation by remaining weight.
REQ-019 pixel_out = (sum + 8) >> 4, i.e. round half up; the result always fits in 8 bits, so no saturation.
REQ-020 pixel_out SHALL be combinational from the window registers and the current edge flags (edge change visible in the same cycle, no clock needed).
REQ-021 A 2-bit fill counter SHALL count accepted columns, saturating at 3.
REQ-022 valid_out SHALL be registered: on each rising clk, valid_out <= valid_in AND (fill count >= 2 before this shift), i.e. high for one cycle after each shift that produces a full window.
REQ-023 Edge flags SHALL NOT affect window contents, the fill counter, or valid_out.

Reset
REQ-024 While rst_n=1 at a rising clk: all window pixels <= 0, fill counter <= 0, valid_out <= 0; valid_in is ignored that cycle.
REQ-025 After reset, pixel_out = 0 (window all zero) until columns are loaded.

Verification
REQ-026 Uniform: shift columns (16,16,16) x3, then edges {top,bot,left,right}=0000 -> 16; 0001 -> 12; 1010 -> 9.
REQ-027 Columns c0=(55,30,25), c1=(25,255,230), c2=(10,50,130); edges 0000 -> 119; 0001 -> 104; 0110 -> 74; 1001 -> 98; 0101 -> 74; 1010 -> 107.
REQ-028 Columns c0=(255,44,77), c1=(80,240,179), c2=(165,231,79); edges 0000 -> 163; 0001 -> 119; 0110 -> 109; 1001 -> 93; 0101 -> 91; 1010 -> 116.
REQ-029 Hold: valid_in=0 for several cycles with edge changes -> window unchanged, pixel_out tracks edges in the same cycle, valid_out=0.
REQ-030 Fill/valid: after reset, 3 consecutive valid_in cycles -> valid_out 0, 0, then 1 in the cycle after the third shift; an all-255 window with edges 0000 -> 255.
REQ-031 Reset mid-stream: rst_n=1 for one clk with valid_in=1 -> window zero, pixel_out=0, valid_out=0, and the fill count restarts (3 new columns are needed before valid_out=1).

Source files
------------

// File: rtl/kernel_3x3_gauss.sv
// 3x3 Gaussian kernel (1-2-1 / 2-4-2 / 1-2-1) over a sliding window of
// pixel columns, with per-row/per-column edge zeroing and round-half-up output.
module kernel_3x3_gauss (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] top,
  input  logic [7:0] mid,
  input  logic [7:0] bot,
  input  logic       valid_in,
  input  logic       top_edge,
  input  logic       bot_edge,
  input  logic       left_edge,
  input  logic       right_edge,
  output logic [7:0] pixel_out,
  output logic       valid_out
);

  localparam int unsigned PW = 8;
  localparam int unsigned SW = 12;
  localparam int unsigned NC = 3;

  // win[col][row]: col 0 oldest, col 2 newest; row 0 top, row 2 bottom
  logic [NC-1:0][NC-1:0][PW-1:0] win;
  logic [1:0]                    fill;
  logic [NC-1:0]                 row_zero;
  logic [NC-1:0]                 col_zero;
  logic [SW-1:0]                 sum;
  logic [SW-1:0]                 rounded;

  // Window shift, fill count and registered valid; rst_n is active-high here
  always_ff @(posedge clk) begin
    if (rst_n) begin
      win       <= '0;
      fill      <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in && (fill >= 2'd2);
      if (valid_in) begin
        win[0]    <= win[1];
        win[1]    <= win[2];
        win[2][0] <= top;
        win[2][1] <= mid;
        win[2][2] <= bot;
        if (fill != 2'd3) fill <= fill + 2'd1;
      end
    end
  end

  assign row_zero = {bot_edge, 1'b0, top_edge};
  assign col_zero = {right_edge, 1'b0, left_edge};

  // Masked weighted sum; a pixel flagged by both a row and a column edge is zeroed once
  always_comb begin
    sum = '0;
    for (int c = 0; c < NC; c++) begin
      for (int r = 0; r < NC; r++) begin
        if (!(row_zero[r] || col_zero[c])) begin
          if (r == 1 && c == 1)
            sum = sum + (SW'(win[c][r]) << 2);
          else if (r == 1 || c == 1)
            sum = sum + (SW'(win[c][r]) << 1);
          else
            sum = sum + SW'(win[c][r]);
        end
      end
    end
  end

  // Max sum 4080 + 8 still fits in 12 bits, so no saturation is needed
  assign rounded   = sum + SW'(8);
  assign pixel_out = rounded[SW-1:4];

endmodule

// File: tb/tb_kernel_3x3_gauss.sv
// Scoreboard bench for kernel_3x3_gauss: driver pushes expected per-cycle
// results, monitor pops and compares on the falling edge.
module tb_kernel_3x3_gauss;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] top, mid, bot;
  logic       valid_in;
  logic       top_edge, bot_edge, left_edge, right_edge;
  logic [7:0] pixel_out;
  logic       valid_out;

  always #5 clk = ~clk;

  kernel_3x3_gauss dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .top        (top),
    .mid        (mid),
    .bot        (bot),
    .valid_in   (valid_in),
    .top_edge   (top_edge),
    .bot_edge   (bot_edge),
    .left_edge  (left_edge),
    .right_edge (right_edge),
    .pixel_out  (pixel_out),
    .valid_out  (valid_out)
  );

  typedef struct {
    logic       exp_vo;
    bit         chk_pix;
    logic [7:0] exp_pix;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Expected-valid model: state describing the inputs driven in the previous cycle
  bit   m_prev_rst = 1'b1;
  bit   m_prev_v   = 1'b0;
  int   m_fill     = 0;

  task automatic step(input bit rs, input bit v,
                      input logic [7:0] t, input logic [7:0] m, input logic [7:0] b,
                      input logic [3:0] e, input bit chk, input logic [7:0] px,
                      input string nm);
    exp_t x;
    @(posedge clk);
    x.exp_vo = !m_prev_rst && m_prev_v && (m_fill >= 2);
    if (m_prev_rst) m_fill = 0;
    else if (m_prev_v && m_fill < 3) m_fill++;
    m_prev_rst = rs;
    m_prev_v   = v;
    #1;
    rst_n    = rs;
    valid_in = v;
    top = t; mid = m; bot = b;
    {top_edge, bot_edge, left_edge, right_edge} = e;
    x.chk_pix = chk;
    x.exp_pix = px;
    x.name    = nm;
    sb.push_back(x);
  endtask

  task automatic col(input logic [7:0] t, input logic [7:0] m, input logic [7:0] b);
    step(1'b0, 1'b1, t, m, b, 4'b0000, 1'b0, 8'd0, "shift");
  endtask

  task automatic hold(input logic [3:0] e, input logic [7:0] px, input string nm);
    step(1'b0, 1'b0, 8'hA5, 8'h5A, 8'hC3, e, 1'b1, px, nm);
  endtask

  // Monitor: compare every cycle's valid_out, and pixel_out where requested
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        n_tests++;
        if (valid_out !== x.exp_vo) begin
          n_fail++;
          $display("FAIL %s valid_out: got %0b expected %0b", x.name, valid_out, x.exp_vo);
        end
        if (x.chk_pix) begin
          n_tests++;
          if (pixel_out !== x.exp_pix) begin
            n_fail++;
            $display("FAIL %s pixel_out: got %0d expected %0d", x.name, pixel_out, x.exp_pix);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1; valid_in = 1'b0;
    top = '0; mid = '0; bot = '0;
    {top_edge, bot_edge, left_edge, right_edge} = 4'b0000;

    step(1'b1, 1'b1, 8'd9, 8'd9, 8'd9, 4'b0000, 1'b1, 8'd0, "reset");
    step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 4'b0000, 1'b1, 8'd0, "reset_zero");

    // Fill / valid sequence with an all-255 window
    col(8'd255, 8'd255, 8'd255);
    col(8'd255, 8'd255, 8'd255);
    col(8'd255, 8'd255, 8'd255);
    hold(4'b0000, 8'd255, "all255");

    // Uniform 16
    col(8'd16, 8'd16, 8'd16);
    col(8'd16, 8'd16, 8'd16);
    col(8'd16, 8'd16, 8'd16);
    hold(4'b0000, 8'd16, "uni_0000");
    hold(4'b0001, 8'd12, "uni_0001");
    hold(4'b1010, 8'd9,  "uni_1010");

    // Mixed window A, with hold and edge changes while valid_in=0
    col(8'd55, 8'd30,  8'd25);
    col(8'd25, 8'd255, 8'd230);
    col(8'd10, 8'd50,  8'd130);
    hold(4'b0000, 8'd119, "a_0000");
    hold(4'b0001, 8'd104, "a_0001");
    hold(4'b0110, 8'd74,  "a_0110");
    hold(4'b1001, 8'd98,  "a_1001");
    hold(4'b0101, 8'd74,  "a_0101");
    hold(4'b1010, 8'd107, "a_1010");
    hold(4'b0000, 8'd119, "a_back");

    // Mixed window B
    col(8'd255, 8'd44,  8'd77);
    col(8'd80,  8'd240, 8'd179);
    col(8'd165, 8'd231, 8'd79);
    hold(4'b0000, 8'd163, "b_0000");
    hold(4'b0001, 8'd119, "b_0001");
    hold(4'b0110, 8'd109, "b_0110");
    hold(4'b1001, 8'd93,  "b_1001");
    hold(4'b0101, 8'd91,  "b_0101");
    hold(4'b1010, 8'd116, "b_1010");

    // Reset mid-stream with valid_in high, then fill must restart
    step(1'b1, 1'b1, 8'd99, 8'd99, 8'd99, 4'b0000, 1'b0, 8'd0, "rst_mid");
    hold(4'b0000, 8'd0, "rst_zero");
    col(8'd16, 8'd16, 8'd16);
    col(8'd16, 8'd16, 8'd16);
    col(8'd16, 8'd16, 8'd16);
    hold(4'b0000, 8'd16, "refill");

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
